// File: rtl/mem_ctrl.sv
// mem_ctrl: shares one byte-wide RAM port between fetch and data access.
// Serializes 32-bit accesses into byte transfers and drives the pipeline lock.
module mem_ctrl (
    input  logic        clk,
    input  logic        rst,
    input  logic        if_req,
    input  logic [31:0] if_addr,
    output logic [31:0] if_data,
    output logic        if_done,
    input  logic        mem_req,
    input  logic        mem_we,
    input  logic [31:0] mem_addr,
    input  logic [1:0]  mem_size,
    input  logic [31:0] mem_wdata,
    output logic [31:0] mem_rdata,
    output logic        mem_done,
    output logic [31:0] ram_addr,
    output logic        ram_wr,
    output logic [7:0]  ram_dout,
    input  logic [7:0]  ram_din,
    output logic [4:0]  lock
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_FETCH,
        S_LOAD,
        S_STORE
    } state_t;

    state_t      state_q;
    logic [2:0]  cnt_q;
    logic [2:0]  n_q;
    logic [31:0] wdata_q;
    logic [31:0] acc_q;
    logic [31:0] if_data_q;
    logic [31:0] mem_rdata_q;
    logic [31:0] ram_addr_q;
    logic        ram_wr_q;
    logic [7:0]  ram_dout_q;

    logic [2:0]  cnt_d;
    logic [1:0]  rd_idx;
    logic [1:0]  wr_idx_d;
    logic [31:0] rd_word_d;
    logic        rd_last;
    logic        wr_last;
    logic        any_done;

    // Byte count of an access from its size code.
    function automatic logic [2:0] size_to_n(input logic [1:0] size);
        logic [2:0] n;
        unique case (size)
            2'd0:    n = 3'd1;
            2'd1:    n = 3'd2;
            default: n = 3'd4;
        endcase
        return n;
    endfunction

    // Read assembly: the byte arriving now lands in lane cnt-1.
    always_comb begin
        cnt_d     = cnt_q + 3'd1;
        rd_idx    = 2'(cnt_q - 3'd1);
        wr_idx_d  = cnt_d[1:0];
        rd_word_d = acc_q;
        rd_word_d[{rd_idx, 3'b000} +: 8] = ram_din;
        rd_last   = (state_q == S_FETCH || state_q == S_LOAD)
                    && cnt_q == n_q;
        wr_last   = (state_q == S_STORE) && cnt_q == (n_q - 3'd1);
        any_done  = rd_last || wr_last;
    end

    // Done pulses, result mux and pipeline lock.
    always_comb begin
        if_done   = (state_q == S_FETCH) && rd_last;
        mem_done  = ((state_q == S_LOAD) && rd_last) || wr_last;
        if_data   = if_done ? rd_word_d : if_data_q;
        mem_rdata = (state_q == S_LOAD && rd_last) ? rd_word_d
                                                   : mem_rdata_q;
        lock      = 5'b00000;
        if (rst) begin
            lock = 5'b00000;
        end else if (state_q != S_IDLE) begin
            lock = any_done ? 5'b00000 : 5'b11111;
        end else if (if_req || mem_req) begin
            lock = 5'b11111;
        end
    end

    assign ram_addr = ram_addr_q;
    assign ram_wr   = ram_wr_q;
    assign ram_dout = ram_dout_q;

    // Access sequencer: arbitration, byte stepping and result capture.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            cnt_q       <= 3'd0;
            n_q         <= 3'd4;
            wdata_q     <= 32'd0;
            acc_q       <= 32'd0;
            if_data_q   <= 32'd0;
            mem_rdata_q <= 32'd0;
            ram_addr_q  <= 32'd0;
            ram_wr_q    <= 1'b0;
            ram_dout_q  <= 8'd0;
        end else begin
            unique case (state_q)
                S_IDLE: begin
                    cnt_q <= 3'd0;
                    acc_q <= 32'd0;
                    if (mem_req) begin
                        ram_addr_q <= mem_addr;
                        n_q        <= size_to_n(mem_size);
                        wdata_q    <= mem_wdata;
                        if (mem_we) begin
                            state_q    <= S_STORE;
                            ram_wr_q   <= 1'b1;
                            ram_dout_q <= mem_wdata[7:0];
                        end else begin
                            state_q <= S_LOAD;
                        end
                    end else if (if_req) begin
                        state_q    <= S_FETCH;
                        ram_addr_q <= if_addr;
                        n_q        <= 3'd4;
                    end
                end
                S_FETCH, S_LOAD: begin
                    if (cnt_q != 3'd0) begin
                        acc_q <= rd_word_d;
                    end
                    if (rd_last) begin
                        state_q <= S_IDLE;
                        cnt_q   <= 3'd0;
                        if (state_q == S_FETCH) begin
                            if_data_q <= rd_word_d;
                        end else begin
                            mem_rdata_q <= rd_word_d;
                        end
                    end else begin
                        cnt_q <= cnt_d;
                        if (cnt_d < n_q) begin
                            ram_addr_q <= ram_addr_q + 32'd1;
                        end
                    end
                end
                S_STORE: begin
                    if (wr_last) begin
                        state_q  <= S_IDLE;
                        cnt_q    <= 3'd0;
                        ram_wr_q <= 1'b0;
                    end else begin
                        cnt_q      <= cnt_d;
                        ram_addr_q <= ram_addr_q + 32'd1;
                        ram_dout_q <= wdata_q[{wr_idx_d, 3'b000} +: 8];
                    end
                end
                default: begin
                    state_q  <= S_IDLE;
                    ram_wr_q <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_ctrl.sv
// tb_mem_ctrl: byte RAM model, directed vector table, hand sequences for
// contention and reset, and random accesses checked against a memory model.
module tb_mem_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        if_req;
    logic [31:0] if_addr;
    logic [31:0] if_data;
    logic        if_done;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [1:0]  mem_size;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        mem_done;
    logic [31:0] ram_addr;
    logic        ram_wr;
    logic [7:0]  ram_dout;
    logic [7:0]  ram_din;
    logic [4:0]  lock;

    int n_cmp = 0;
    int n_bad = 0;

    logic [7:0]  ram     [0:4095];
    logic [7:0]  ref_mem [0:4095];
    logic        clr;
    logic        poke_en;
    logic [11:0] poke_a;
    logic [7:0]  poke_d;

    always #5 clk = ~clk;

    mem_ctrl dut (
        .clk       (clk),
        .rst       (rst),
        .if_req    (if_req),
        .if_addr   (if_addr),
        .if_data   (if_data),
        .if_done   (if_done),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_size  (mem_size),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .mem_done  (mem_done),
        .ram_addr  (ram_addr),
        .ram_wr    (ram_wr),
        .ram_dout  (ram_dout),
        .ram_din   (ram_din),
        .lock      (lock)
    );

    // Synchronous byte RAM, aliased on the low 12 address bits.
    always @(posedge clk) begin
        if (clr) begin
            for (int i = 0; i < 4096; i++) ram[i] <= 8'h00;
        end else if (poke_en) begin
            ram[poke_a] <= poke_d;
        end else if (ram_wr) begin
            ram[ram_addr[11:0]] <= ram_dout;
        end
        ram_din <= ram[ram_addr[11:0]];
    end

    task automatic check(input string nm, input logic [31:0] act,
                         input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %08h expected %08h", nm, act, exp);
        end
    endtask

    task automatic poke(input logic [31:0] a, input logic [7:0] d);
        @(negedge clk);
        poke_en = 1'b1;
        poke_a  = a[11:0];
        poke_d  = d;
        ref_mem[a[11:0]] = d;
        @(negedge clk);
        poke_en = 1'b0;
    endtask

    function automatic int nbytes(input int kind, input logic [1:0] size);
        if (kind == 0 || size >= 2'd2) return 4;
        return (size == 2'd0) ? 1 : 2;
    endfunction

    function automatic logic [31:0] model_read(input logic [31:0] a,
                                               input int n);
        logic [31:0] r;
        logic [31:0] p;
        r = 32'd0;
        for (int k = 0; k < n; k++) begin
            p = a + 32'(k);
            r = r | (32'(ref_mem[p[11:0]]) << (8 * k));
        end
        return r;
    endfunction

    // kind: 0 fetch, 1 load, 2 store. Checks every cycle of the access.
    task automatic do_access(input int kind, input logic [31:0] addr,
                             input logic [1:0] size,
                             input logic [31:0] wdata,
                             output logic [31:0] got);
        int n;
        int done_t;
        logic [31:0] exp_rd;
        logic [31:0] p;
        logic dn;
        n      = nbytes(kind, size);
        done_t = (kind == 2) ? n : n + 1;
        exp_rd = model_read(addr, n);
        got    = 32'd0;
        @(negedge clk);
        if (kind == 0) begin
            if_req  = 1'b1;
            if_addr = addr;
        end else begin
            mem_req   = 1'b1;
            mem_we    = (kind == 2);
            mem_addr  = addr;
            mem_size  = size;
            mem_wdata = wdata;
        end
        if (kind == 2) begin
            for (int k = 0; k < n; k++) begin
                p = addr + 32'(k);
                ref_mem[p[11:0]] = 8'(wdata >> (8 * k));
            end
        end
        #1;
        check("lock_t0", 32'(lock), 32'h1F);
        for (int t = 1; t <= done_t; t++) begin
            @(negedge clk);
            if (t <= n) begin
                check("ram_addr", ram_addr, addr + 32'(t - 1));
                check("ram_wr", 32'(ram_wr), (kind == 2) ? 32'd1 : 32'd0);
                if (kind == 2)
                    check("ram_dout", 32'(ram_dout),
                          (wdata >> (8 * (t - 1))) & 32'hFF);
            end
            dn = (kind == 0) ? if_done : mem_done;
            if (t < done_t) begin
                check("done_early", 32'(dn), 32'd0);
                check("lock_busy", 32'(lock), 32'h1F);
            end else begin
                check("done_pulse", 32'(dn), 32'd1);
                check("lock_done", 32'(lock), 32'h00);
                got = (kind == 0) ? if_data : mem_rdata;
                if (kind != 2) check("rd_model", got, exp_rd);
            end
        end
        if_req  = 1'b0;
        mem_req = 1'b0;
        mem_we  = 1'b0;
        @(negedge clk);
        check("idle_lock", 32'(lock), 32'h00);
        check("idle_wr", 32'(ram_wr), 32'd0);
        check("idle_done", 32'({if_done, mem_done}), 32'd0);
    endtask

    typedef struct {
        int          kind;
        logic [31:0] addr;
        logic [1:0]  size;
        logic [31:0] wdata;
        logic [31:0] exp;
    } vec_t;

    vec_t        tbl [12];
    logic [31:0] got;

    initial begin
        rst = 1'b1; clr = 1'b1; poke_en = 1'b0;
        poke_a = '0; poke_d = '0;
        if_req = 1'b0; if_addr = '0;
        mem_req = 1'b0; mem_we = 1'b0; mem_addr = '0;
        mem_size = '0; mem_wdata = '0;
        for (int i = 0; i < 4096; i++) ref_mem[i] = 8'h00;

        tbl[0]  = '{0, 32'h100, 2'd2, 32'h0, 32'h00000513};
        tbl[1]  = '{1, 32'h201, 2'd0, 32'h0, 32'h000000F0};
        tbl[2]  = '{1, 32'h200, 2'd1, 32'h0, 32'h0000F034};
        tbl[3]  = '{2, 32'h300, 2'd2, 32'hDEADBEEF, 32'h0};
        tbl[4]  = '{1, 32'h300, 2'd2, 32'h0, 32'hDEADBEEF};
        tbl[5]  = '{2, 32'h400, 2'd0, 32'h123456AB, 32'h0};
        tbl[6]  = '{1, 32'h400, 2'd2, 32'h0, 32'h000000AB};
        tbl[7]  = '{2, 32'h410, 2'd1, 32'h9876CAFE, 32'h0};
        tbl[8]  = '{1, 32'h410, 2'd3, 32'h0, 32'h0000CAFE};
        tbl[9]  = '{0, 32'hFFFFFFFE, 2'd0, 32'h0, 32'h44332211};
        tbl[10] = '{1, 32'h300, 2'd3, 32'h0, 32'hDEADBEEF};
        tbl[11] = '{1, 32'h302, 2'd1, 32'h0, 32'h0000DEAD};

        repeat (3) @(negedge clk);
        check("rst_ram_addr", ram_addr, 32'd0);
        check("rst_ram_wr", 32'(ram_wr), 32'd0);
        check("rst_ram_dout", 32'(ram_dout), 32'd0);
        check("rst_if_data", if_data, 32'd0);
        check("rst_mem_rdata", mem_rdata, 32'd0);
        check("rst_dones", 32'({if_done, mem_done}), 32'd0);
        check("rst_lock", 32'(lock), 32'd0);
        rst = 1'b0;
        clr = 1'b0;
        @(negedge clk);
        check("post_rst_lock", 32'(lock), 32'd0);

        poke(32'h100, 8'h13); poke(32'h101, 8'h05);
        poke(32'h102, 8'h00); poke(32'h103, 8'h00);
        poke(32'h200, 8'h34); poke(32'h201, 8'hF0);
        poke(32'hFFE, 8'h11); poke(32'hFFF, 8'h22);
        poke(32'h000, 8'h33); poke(32'h001, 8'h44);

        for (int i = 0; i < 12; i++) begin
            do_access(tbl[i].kind, tbl[i].addr, tbl[i].size,
                      tbl[i].wdata, got);
            if (tbl[i].kind != 2) check("vec_data", got, tbl[i].exp);
        end

        // Contention: both requests in one IDLE cycle, MEM goes first.
        @(negedge clk);
        if_req = 1'b1; if_addr = 32'h100;
        mem_req = 1'b1; mem_we = 1'b0; mem_addr = 32'h201; mem_size = 2'd0;
        #1;
        check("ct_lock_t0", 32'(lock), 32'h1F);
        @(negedge clk);
        check("ct_mem_first", ram_addr, 32'h201);
        @(negedge clk);
        check("ct_mem_done", 32'(mem_done), 32'd1);
        check("ct_mem_data", mem_rdata, 32'h000000F0);
        check("ct_if_wait", 32'(if_done), 32'd0);
        check("ct_lock_done", 32'(lock), 32'h00);
        mem_req = 1'b0;
        @(negedge clk);
        check("ct_idle_lock", 32'(lock), 32'h1F);
        check("ct_idle_wr", 32'(ram_wr), 32'd0);
        @(negedge clk);
        check("ct_fetch_a0", ram_addr, 32'h100);
        mem_req = 1'b1; mem_we = 1'b0; mem_addr = 32'h200; mem_size = 2'd1;
        for (int t = 1; t < 4; t++) begin
            @(negedge clk);
            check("ct_fetch_a", ram_addr, 32'h100 + 32'(t));
            check("ct_no_preempt", 32'(mem_done), 32'd0);
            check("ct_lock_busy", 32'(lock), 32'h1F);
        end
        @(negedge clk);
        check("ct_if_done", 32'(if_done), 32'd1);
        check("ct_if_data", if_data, 32'h00000513);
        check("ct_lock_ifd", 32'(lock), 32'h00);
        if_req = 1'b0;
        @(negedge clk);
        check("ct_idle2_lock", 32'(lock), 32'h1F);
        @(negedge clk);
        check("ct_load_a0", ram_addr, 32'h200);
        @(negedge clk);
        check("ct_load_a1", ram_addr, 32'h201);
        @(negedge clk);
        check("ct_load_done", 32'(mem_done), 32'd1);
        check("ct_load_data", mem_rdata, 32'h0000F034);
        mem_req = 1'b0;
        @(negedge clk);
        check("ct_end_lock", 32'(lock), 32'h00);

        // Reset after two bytes of a word store.
        @(negedge clk);
        mem_req = 1'b1; mem_we = 1'b1; mem_addr = 32'h500;
        mem_size = 2'd2; mem_wdata = 32'h11223344;
        @(negedge clk);
        check("rs_wr0", 32'(ram_wr), 32'd1);
        check("rs_a0", ram_addr, 32'h500);
        @(negedge clk);
        check("rs_a1", ram_addr, 32'h501);
        check("rs_d1", 32'(ram_dout), 32'h33);
        rst = 1'b1;
        mem_req = 1'b0; mem_we = 1'b0;
        #1;
        check("rs_lock_in_rst", 32'(lock), 32'h00);
        @(negedge clk);
        check("rs_wr_off", 32'(ram_wr), 32'd0);
        check("rs_lock", 32'(lock), 32'h00);
        check("rs_done", 32'(mem_done), 32'd0);
        check("rs_if_data", if_data, 32'd0);
        check("rs_mem_rdata", mem_rdata, 32'd0);
        check("rs_ram_addr", ram_addr, 32'd0);
        rst = 1'b0;
        @(negedge clk);
        check("rs_after_lock", 32'(lock), 32'h00);
        check("rs_after_wr", 32'(ram_wr), 32'd0);
        ref_mem[12'h500] = 8'h44;
        ref_mem[12'h501] = 8'h33;
        do_access(1, 32'h500, 2'd2, 32'h0, got);
        check("rs_partial", got, 32'h00003344);

        // Random mix of fetch/load/store over a small shared window.
        for (int i = 0; i < 80; i++) begin
            int          kind;
            logic [31:0] a;
            logic [1:0]  sz;
            logic [31:0] wd;
            kind = int'($urandom_range(0, 2));
            a    = 32'h800 + 32'($urandom_range(0, 255));
            sz   = 2'($urandom_range(0, 3));
            wd   = $urandom;
            repeat ($urandom_range(0, 2)) @(negedge clk);
            do_access(kind, a, sz, wd, got);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/mem_ctrl.md
# mem_ctrl

Single-port memory controller and pipeline stall scheduler for the 5-stage RISC-V core. Shares one byte-wide RAM port between instruction fetch (IF) and data access (MEM), serializes 32-bit accesses into byte transfers, and drives the 5-bit `lock` vector that freezes the pc, if_id, id_ex, ex_mem and mem_wb registers while an access is outstanding.

## Interface
Parameters: none (widths from `defines.v`: `RegBus`=32).
- `clk` in 1: the only clock.
- `rst` in 1: synchronous, active-high (`RstEnable`).
- `if_req` in 1: IF requests a 32-bit instruction fetch.
- `if_addr` in 32: fetch byte address.
- `if_data` out 32: fetched instruction, little-endian.
- `if_done` out 1: one-cycle pulse; `if_data` valid this cycle.
- `mem_req` in 1: MEM requests a load or store.
- `mem_we` in 1: 1 = store, 0 = load.
- `mem_addr` in 32: data byte address.
- `mem_size` in 2: 0 byte, 1 half, 2 or 3 word.
- `mem_wdata` in 32: store data, low bytes used.
- `mem_rdata` out 32: load data, zero-filled above `mem_size` (MEM stage sign-extends).
- `mem_done` out 1: one-cycle pulse; load data valid / store finished.
- `ram_addr` out 32: RAM byte address.
- `ram_wr` out 1: RAM write strobe.
- `ram_dout` out 8: RAM write byte.
- `ram_din` in 8: RAM read byte, valid the cycle after its address.
- `lock` out 5: bit0 pc, bit1 if_id, bit2 id_ex, bit3 ex_mem, bit4 mem_wb; 1 = hold.

## Operation
- States: IDLE, FETCH, LOAD, STORE; byte counter `cnt` 0..3; byte count `n` = 1, 2, 4 from size (fetch always 4).
- IDLE: at edge, `mem_req` has priority: `mem_we`=1 -> STORE, else LOAD; else `if_req` -> FETCH; else stay. Latch address, size, wdata; `cnt`=0.
- FETCH/LOAD: `ram_addr` = base+`cnt` for `cnt` = 0..n-1, `ram_wr`=0; byte k from `ram_din` the cycle after its address goes into bits [8k+7:8k]. In the cycle the last byte arrives, pulse done with full data, return to IDLE.
- STORE: `ram_addr` = base+`cnt`, `ram_dout` = wdata byte `cnt`, `ram_wr`=1 for `cnt` = 0..n-1. Pulse `mem_done` in the last write cycle, return to IDLE.
- No preemption: a `mem_req` arriving during FETCH waits until fetch completes.
- The done cycle always returns to IDLE. Requests are not sampled in it, so the request that just completed is never reissued. Every access is followed by at least one IDLE cycle.
- `lock` is combinational:
  - 5'b11111 when state is not IDLE and no done pulse this cycle.
  - 5'b11111 when state is IDLE and (`if_req` or `mem_req`).
  - Otherwise 5'b00000.
  - In the done cycle `lock`=0, so the whole pipeline advances and captures the result.
  - Holding mem_wb re-presents an identical register write, which is idempotent.
- `if_data` and `mem_rdata` hold their last value until the next access of their type overwrites them.
- Addresses wrap mod 2^32 (base+`cnt`). Alignment is not checked.

## Timing
- Reset, applied in any state including mid-access:
  - State IDLE, `cnt`=0.
  - `ram_addr`=0, `ram_wr`=0, `ram_dout`=0.
  - `if_data`=0, `mem_rdata`=0, `if_done`=0, `mem_done`=0.
  - `lock`=0 while `rst` is high.
  - A partial store is abandoned; bytes already written stay written.
- T0 = IDLE cycle in which the request is sampled. First RAM address is at T1.
- Word fetch/load: addresses T1–T4, done at T5. Half load: done at T3. Byte load: done at T2.
- Word store: writes T1–T4, done at T4. Half store: done at T2. Byte store: done at T1.
- `lock`=1 from T0 through the cycle before done; 0 in the done cycle.
- `ram_wr` is 0 in every non-STORE cycle.

## Test plan
- Word fetch: RAM[0x100..0x103]=13,05,00,00; `if_req`=1, `if_addr`=0x100 -> `ram_addr` 0x100..0x103 at T1–T4, `if_done` at T5, `if_data`=0x00000513, `lock`=11111 for T0–T4, 00000 at T5.
- Byte/half load: RAM[0x201]=0xF0 -> `mem_size`=0 gives `mem_rdata`=0x000000F0 at T2. Half load at 0x200 with RAM[0x200]=0x34 gives 0x0000F034 at T3.
- Word store: `mem_addr`=0x300, `mem_wdata`=0xDEADBEEF -> `ram_dout`=EF,BE,AD,DE with `ram_wr`=1 at T1–T4, `mem_done` at T4; readback via load gives 0xDEADBEEF.
- Contention: `if_req` and `mem_req` asserted in the same IDLE cycle -> MEM served first. Then exactly one IDLE cycle, then FETCH. A `mem_req` raised during FETCH waits until `if_done`.
- Reset mid-store after 2 bytes -> next cycle IDLE, `ram_wr`=0, `lock`=0. Bytes 0–1 are written, bytes 2–3 unchanged.
- Address wrap: word fetch at 0xFFFFFFFE -> `ram_addr` sequence FFFFFFFE, FFFFFFFF, 0, 1.
